counter_ctrl: RTL

Front-end control stage that sits directly upstream of `updown_counter`. It converts four raw, bouncing push-buttons and a 4-bit switch bank into the counter's `load`, `up_down`, `enable` and `d_in` inputs. It uses per-button synchronisation and debounce, single-cycle press detection, and a small run/stop state machine. All outputs are registered and connect port-for-port to the counter.

---
 rtl/counter_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/counter_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the push-button front end of updown_counter.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEFAULT_WIDTH           = 4;

    // Button indices into the packed press vector.
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_PAUSE = 2;
    localparam int unsigned BTN_LOAD  = 3;
    localparam int unsigned NUM_BTNS  = 4;

    // Stability counter width for a debounce length of n cycles.
    function automatic int unsigned debounce_cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, N-cycle debouncer and a one-cycle
// registered press pulse on each debounced 0->1 transition.
module btn_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Level flips on the Nth consecutive cycle the synchronised input differs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Converts raw buttons and switches into registered load/up_down/enable/d_in
// controls for updown_counter, with a run/stop state machine.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned WIDTH           = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_pause,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw_d,
    output logic             load,
    output logic             up_down,
    output logic             enable,
    output logic [WIDTH-1:0] d_in
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;
    logic [WIDTH-1:0]    sw_s1;
    logic [WIDTH-1:0]    sw_s2;
    ctrl_state_t         state;
    ctrl_state_t         state_nxt;
    logic                last_dir;
    logic                dir_nxt;

    always_comb begin
        btn_raw            = '0;
        btn_raw[BTN_UP]    = btn_up;
        btn_raw[BTN_DOWN]  = btn_down;
        btn_raw[BTN_PAUSE] = btn_pause;
        btn_raw[BTN_LOAD]  = btn_load;
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .press(press[i])
        );
    end

    // Switches are static settings, so synchronising without debounce is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_d;
            sw_s2 <= sw_s1;
        end
    end

    // Next state: pause beats up beats down; load never touches the state.
    always_comb begin
        state_nxt = state;
        dir_nxt   = last_dir;
        if (press[BTN_PAUSE]) begin
            if (state == ST_STOP) begin
                state_nxt = last_dir ? ST_UP : ST_DOWN;
            end else begin
                state_nxt = ST_STOP;
            end
        end else if (press[BTN_UP]) begin
            state_nxt = ST_UP;
            dir_nxt   = 1'b1;
        end else if (press[BTN_DOWN]) begin
            state_nxt = ST_DOWN;
            dir_nxt   = 1'b0;
        end
    end

    // Outputs are derived from the next state so they land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            last_dir <= 1'b1;
            enable   <= 1'b0;
            up_down  <= 1'b1;
            load     <= 1'b0;
            d_in     <= '0;
        end else begin
            state    <= state_nxt;
            last_dir <= dir_nxt;
            enable   <= (state_nxt != ST_STOP);
            if (state_nxt == ST_UP) begin
                up_down <= 1'b1;
            end else if (state_nxt == ST_DOWN) begin
                up_down <= 1'b0;
            end
            load <= press[BTN_LOAD];
            if (press[BTN_LOAD]) begin
                d_in <= sw_s2;
            end
        end
    end

endmodule
